// File: rtl/hall_commutator.sv
// Hall-sensor rotor-position receiver: synchronizes and debounces the three hall lines,
// drives the per-phase commutation selects, and measures step period, direction and faults.
module hall_commutator #(
  parameter int DBNC_CYCLES = 4,
  parameter int PER_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hallGrn,
  input  logic             hallYlw,
  input  logic             hallBlu,
  input  logic             enable,
  input  logic             brake,
  output logic [1:0]       selGrn,
  output logic [1:0]       selYlw,
  output logic [1:0]       selBlu,
  output logic [PER_W-1:0] rotation_period,
  output logic             period_vld,
  output logic             dir,
  output logic             hall_err,
  output logic             stall
);

  localparam int DW = $clog2(DBNC_CYCLES + 1);
  localparam logic [DW-1:0] DBNC_MAX = DW'(DBNC_CYCLES);
  localparam logic [DW-1:0] DBNC_ACC = DW'(DBNC_CYCLES - 1);
  localparam logic [PER_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    SEL_HIGH_Z = 2'b00,
    SEL_REV    = 2'b01,
    SEL_FWD    = 2'b10,
    SEL_BRAKE  = 2'b11
  } sel_e;

  logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]       h_prev_q, h_prev_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [2:0]       rot_q, rot_d;
  logic             ref_q, ref_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             pvld_q, pvld_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [5:0]       sel_q, sel_d;

  logic [2:0] h;
  logic       accept, new_legal, cur_legal, fwd_step, rev_step;
  logic [2:0] idx_new, idx_cur;

  function automatic logic is_legal(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  // Position of a legal code in the forward sequence 101,100,110,010,011,001.
  function automatic logic [2:0] seq_idx(input logic [2:0] c);
    case (c)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      3'b001:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [5:0] sel_lut(input logic [2:0] c);
    case (c)
      3'b101:  return {SEL_FWD,    SEL_REV,    SEL_HIGH_Z};
      3'b100:  return {SEL_FWD,    SEL_HIGH_Z, SEL_REV};
      3'b110:  return {SEL_HIGH_Z, SEL_FWD,    SEL_REV};
      3'b010:  return {SEL_REV,    SEL_FWD,    SEL_HIGH_Z};
      3'b011:  return {SEL_REV,    SEL_HIGH_Z, SEL_FWD};
      3'b001:  return {SEL_HIGH_Z, SEL_REV,    SEL_FWD};
      default: return {SEL_HIGH_Z, SEL_HIGH_Z, SEL_HIGH_Z};
    endcase
  endfunction

  always_comb begin
    sync1_d  = {hallGrn, hallYlw, hallBlu};
    sync2_d  = sync1_q;
    h        = sync2_q;
    h_prev_d = h;

    if (h != h_prev_q)          dcnt_d = '0;
    else if (dcnt_q != DBNC_MAX) dcnt_d = dcnt_q + DW'(1);
    else                        dcnt_d = dcnt_q;

    accept    = (h == h_prev_q) && (dcnt_q == DBNC_ACC) && (h != rot_q);
    new_legal = is_legal(h);
    cur_legal = is_legal(rot_q);
    idx_new   = seq_idx(h);
    idx_cur   = seq_idx(rot_q);
    fwd_step  = (idx_new == ((idx_cur == 3'd5) ? 3'd0 : idx_cur + 3'd1));
    rev_step  = (idx_cur == ((idx_new == 3'd5) ? 3'd0 : idx_new + 3'd1));

    rot_d  = rot_q;
    ref_d  = ref_q;
    dir_d  = dir_q;
    per_d  = per_q;
    pvld_d = 1'b0;
    err_d  = 1'b0;
    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PER_W'(1);

    if (accept) begin
      rot_d = h;
      if (!new_legal) begin
        err_d = 1'b1;
      end else if (!ref_q) begin
        // First legal code is the timing reference; no step is reported.
        ref_d = 1'b1;
        cnt_d = '0;
      end else if (cur_legal) begin
        pvld_d = 1'b1;
        per_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PER_W'(1);
        cnt_d  = '0;
        if (fwd_step)      dir_d = 1'b1;
        else if (rev_step) dir_d = 1'b0;
        else               err_d = 1'b1;
      end
    end

    if (!enable)                         sel_d = {3{SEL_HIGH_Z}};
    else if (brake)                      sel_d = {3{SEL_BRAKE}};
    else if (!ref_d || !is_legal(rot_d)) sel_d = {3{SEL_HIGH_Z}};
    else                                 sel_d = sel_lut(rot_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      h_prev_q <= '0;
      dcnt_q   <= '0;
      rot_q    <= '0;
      ref_q    <= 1'b0;
      cnt_q    <= '0;
      per_q    <= '0;
      pvld_q   <= 1'b0;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
      sel_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      h_prev_q <= h_prev_d;
      dcnt_q   <= dcnt_d;
      rot_q    <= rot_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      pvld_q   <= pvld_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      sel_q    <= sel_d;
    end
  end

  assign selGrn          = sel_q[5:4];
  assign selYlw          = sel_q[3:2];
  assign selBlu          = sel_q[1:0];
  assign rotation_period = per_q;
  assign period_vld      = pvld_q;
  assign dir             = dir_q;
  assign hall_err        = err_q;
  assign stall           = (cnt_q == CNT_MAX);

endmodule

// File: doc/hall_commutator.md
# hall_commutator

Rotor-position receiver for the three-phase brushless motor drive. Samples the three asynchronous hall-effect sensor lines, synchronizes and debounces them, and produces the per-phase 2-bit commutation selects consumed by the motor gate driver. It also measures the interval between hall transitions for speed estimation, reports rotation direction, and flags illegal hall codes, skipped steps and stalls.

## Interface
- DBNC_CYCLES, 4: consecutive clk cycles a synchronized hall code must hold before it is accepted (legal range 1–15)
- PER_W, 20: width of the period counter and the rotation_period output
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- hallGrn, hallYlw, hallBlu  in  1 each  raw asynchronous hall sensor inputs
- enable  in  1  0 forces all phases to HIGH_Z
- brake  in  1  1 forces all phases to REGEN_BRAKE (ignored when enable=0)
- selGrn, selYlw, selBlu  out  2 each  commutation selects: 00 HIGH_Z, 01 REV_CURR, 10 FRWRD_CURR, 11 REGEN_BRAKE
- rotation_period  out  PER_W  clk cycles between the last two accepted transitions
- period_vld  out  1  one-cycle pulse when rotation_period updates
- dir  out  1  1 forward, 0 reverse
- hall_err  out  1  one-cycle pulse on illegal code or skipped step
- stall  out  1  level, period counter saturated

## Operation
- Each hall input passes through a 2-flop synchronizer, giving code h = {G,Y,B}.
- Debounce: the stable counter clears whenever h differs from its previous-cycle value. Otherwise it increments, saturating at DBNC_CYCLES. A code is accepted when the count reaches DBNC_CYCLES-1 and h ≠ rot_state. Accepted codes are loaded into rot_state.
- Commutation table (G,Y,B selects) for rot_state:
  - 101 → 10,01,00
  - 100 → 10,00,01
  - 110 → 00,10,01
  - 010 → 01,10,00
  - 011 → 01,00,10
  - 001 → 00,01,10
  - 000 or 111 → all 00
- Select priority, highest first:
  1. enable=0 → all 00
  2. brake=1 → all 11
  3. ref_vld=0 or illegal code → all 00
  4. table lookup
- ref_vld (internal) is cleared by reset. The first accepted legal code sets ref_vld and loads rot_state. This first load produces no period_vld, no hall_err, and no dir change.
- Forward sequence: 101→100→110→010→011→001→101. Reverse is the same sequence traversed backwards.
- Accepted legal code with ref_vld=1:
  - Adjacent forward step → dir=1.
  - Adjacent reverse step → dir=0.
  - Non-adjacent step → hall_err pulse, dir unchanged, period still captured.
- Accepted 000/111: hall_err pulses once on entry, and selects go to 00.
- Leaving an illegal code for a legal one is not a step: ref_vld is already 1, so the code is loaded with no period capture and no dir update. The period counter keeps running.
- Period counter cnt:
  - Increments every cycle, saturating at 2^PER_W−1.
  - On each legal-to-legal accepted transition: rotation_period ← cnt+1, cnt ← 0, period_vld pulses.
- stall is 1 while cnt is saturated. It clears on the cycle after the next legal-to-legal transition.

## Timing
- Reset values:
  - selGrn/selYlw/selBlu = 00, rotation_period = 0, period_vld = 0, dir = 1, hall_err = 0, stall = 0.
  - Internally: cnt = 0, rot_state = 000, ref_vld = 0, synchronizers = 0.
- Latency: a hall pin change held stable is reflected on the sel outputs exactly DBNC_CYCLES+3 clk edges after the first edge that samples the new level (2 synchronizer + DBNC_CYCLES debounce + 1 output register).
- period_vld, hall_err, dir and rotation_period update on the same edge as the new sel values.
- enable and brake are not synchronized. A change on either reaches sel on the next clk edge.
- A glitch shorter than DBNC_CYCLES synchronized cycles is never accepted and has no effect on any output.
- Reset asserted mid-operation returns all outputs to their reset values immediately, since reset is asynchronous. After release, behaviour starts over from "first accepted code" rules.

## Test plan
- Reset: after reset with enable=1, brake=0 and hall=101 held, sel stays 00 until the first code is accepted. Then sel = 10,01,00, with no period_vld and no hall_err.
- Forward rotation: step hall through 101→100→110→010 every 1000 cycles with DBNC_CYCLES=4. Each step gives period_vld with rotation_period=1000, dir=1, and the correct table sel DBNC_CYCLES+3 cycles after the change.
- Reverse rotation, then a skip: 101→001 gives dir=0. Then 001→110 gives a hall_err pulse, dir stays 0, and period_vld still pulses.
- Glitch and illegal codes:
  - A 2-cycle pulse 101→111→101 produces no output change.
  - 111 held for 10 cycles produces a single hall_err pulse and sel all 00.
- Override priority:
  - brake=1 → all 11 next cycle.
  - enable=0 with brake=1 → all 00.
  - Releasing both → table values return next cycle.
- Stall: with PER_W=8, hold hall constant for 300 cycles → stall=1 and cnt=255. The next legal step gives rotation_period=255 (saturated cnt+1 clipped to 255), period_vld, and stall returning to 0.
